frame_stream_source: RTL
========================

// Module: frame_stream_source
// PURPOSE
//  Synthesizable pixel-stream transmitter: drives a frame of raster pixels into the dIn/dInValid/nextDin
//  input of the correction/scaler cores. Replaces file-driven stimulus with on-chip test patterns for
//  bring-up and self-test. Optional leading discard pixels exercise the consumer's clipping path.
// PARAMETERS
//  DATA_WIDTH         8   bits per channel
//  CHANNELS           1   channels per pixel; pattern value replicated across all channels
//  X_RES_WIDTH        11  width of xRes and the column counter
//  Y_RES_WIDTH        11  width of yRes and the row counter
//  DISCARD_CNT_WIDTH  8   width of discardCnt
// PORTS
//  clk         in   1                       single clock; all logic on rising edge
//  rst         in   1                       synchronous, active-high reset
//  start       in   1                       one-cycle pulse; begins a frame (honoured only in IDLE)
//  xRes        in   X_RES_WIDTH             columns-1; sampled at accepted start
//  yRes        in   Y_RES_WIDTH             rows-1; sampled at accepted start
//  discardCnt  in   DISCARD_CNT_WIDTH       dummy pixels (value 0) sent ahead of frame; sampled at start
//  patternSel  in   2                       pattern code; sampled at start
//  dOut        out  DATA_WIDTH*CHANNELS     pixel data to consumer dIn
//  dOutValid   out  1                       dOut holds a valid pixel
//  nextDout    in   1                       consumer ready (its nextDin); beat transfers on dOutValid&&nextDout
//  busy        out  1                       high in DISCARD or STREAM
//  done        out  1                       one-cycle pulse after last frame pixel transfers
// BEHAVIOUR
//  - Reset: state=IDLE, dOut=0, dOutValid=0, busy=0, done=0, counters=0, config registers=0.
//  - FSM IDLE -> (start) DISCARD if discardCnt!=0 else STREAM; DISCARD -> STREAM after discardCnt beats;
//    STREAM -> DONE after beat at (x==xRes, y==yRes); DONE -> IDLE unconditionally (done=1 for this cycle).
//  - Latency: start sampled at edge N -> dOutValid=1 with first beat from edge N+1.
//  - Handshake: dOut/dOutValid only change after a transfer; while dOutValid&&!nextDout, dOut is held stable.
//    Source never drops dOutValid mid-frame; dOutValid=0 in IDLE and DONE.
//  - Raster order: x increments per STREAM beat, wraps to 0 at xRes with y+1; no gaps between rows.
//  - Patterns (8-bit value v, zero-extended/truncated to DATA_WIDTH, MSB-aligned if DATA_WIDTH>8):
//    0 horizontal ramp v=x[7:0]; 1 vertical ramp v=y[7:0]; 2 checker 8x8 v=(x[3]^y[3])?all-ones:0;
//    3 see CONFIGURATION.
//  - start while busy or in DONE: ignored, no config change. start coincident with rst: rst wins.
//  - rst mid-frame: next edge returns IDLE with all outputs at reset values; partial frame abandoned.
//  - xRes=0,yRes=0: exactly one frame pixel; done follows its transfer.
//  - Counters never overflow: xRes/yRes are inclusive limits of equal-width counters.
// CONFIGURATION
//  - Macro FRAME_SOURCE_LFSR_EN defined: pattern 3 = 16-bit Fibonacci LFSR (taps 16,14,13,11), seeded 16'hACE1
//    at each accepted start, advanced once per STREAM transfer, v=lfsr[7:0].
//  - Not defined: pattern 3 = constant mid-grey v=8'h80; no LFSR registers synthesized.
// STRUCTURE
//  - Shared include frame_stream_source_defs.vh: FSM state codes (IDLE,DISCARD,STREAM,DONE),
//    pattern codes (PAT_HRAMP,PAT_VRAMP,PAT_CHECK,PAT_AUX), LFSR seed/taps constants.
//  - One sub-module: stream_pattern_gen (x, y, patternSel, lfsr -> 8-bit v); combinational, reused by
//    future sink-side checkers to predict expected pixels.
//  - Top holds FSM, x/y/discard counters, config capture, output register and channel replication.
// TESTING
//  - xRes=3,yRes=1,disc=0,pat=0,nextDout=1: 8 beats 0,1,2,3,0,1,2,3; done pulse 1 cycle after 8th beat.
//  - Same frame, nextDout toggled 1/0 each cycle: same 8 values in order, dOut stable on stalled cycles.
//  - disc=5,xRes=1,yRes=1,pat=1: 5 beats of 0, then 0,0,1,1; busy high for all 9 beats.
//  - pat=2,xRes=15,yRes=15,CHANNELS=3: pixel(8,0)=24'hFFFFFF, (8,8)=0, (0,0)=0; checksum of 256 beats matches model.
//  - rst asserted after 10th beat of 694x694 frame: next cycle dOutValid=0,busy=0; new start restarts at (0,0).
//  - pat=3: with FRAME_SOURCE_LFSR_EN first beats 8'hE1,8'h70 (seed then one shift); without it, all 8'h80.

Source files
------------

// File: rtl/frame_stream_source_pkg.sv
// Shared definitions for frame_stream_source: FSM state codes, pattern codes, LFSR constants.
// The LFSR constants are only used when FRAME_SOURCE_LFSR_EN is defined.
package frame_stream_source_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DISCARD = 2'd1,
    STREAM  = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [1:0] PAT_HRAMP = 2'd0;
  localparam logic [1:0] PAT_VRAMP = 2'd1;
  localparam logic [1:0] PAT_CHECK = 2'd2;
  localparam logic [1:0] PAT_AUX   = 2'd3;

  localparam logic [7:0]  AUX_GREY  = 8'h80;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Taps 16,14,13,11 counted from the output end of a right-shifting register.
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {^(l & LFSR_TAPS), l[15:1]};
  endfunction

endpackage

// File: rtl/frame_stream_source_pattern_gen.sv
// Combinational test-pattern generator: maps pixel coordinates and pattern code to an 8-bit value.
// Pattern 3 is the LFSR byte with FRAME_SOURCE_LFSR_EN defined, otherwise constant mid-grey.
module stream_pattern_gen
  import frame_stream_source_pkg::*;
(
  input  logic [7:0] x,
  input  logic [7:0] y,
  input  logic [1:0] pattern_sel,
`ifdef FRAME_SOURCE_LFSR_EN
  input  logic [7:0] lfsr,
`endif
  output logic [7:0] v
);

  always_comb begin
    v = '0;
    case (pattern_sel)
      PAT_HRAMP: v = x;
      PAT_VRAMP: v = y;
      PAT_CHECK: v = (x[3] ^ y[3]) ? 8'hFF : 8'h00;
      default: begin
`ifdef FRAME_SOURCE_LFSR_EN
        v = lfsr;
`else
        v = AUX_GREY;
`endif
      end
    endcase
  end

endmodule

// File: rtl/frame_stream_source.sv
// On-chip raster pixel source with valid/ready handshake and optional leading discard pixels.
// Build option FRAME_SOURCE_LFSR_EN turns pattern 3 into a 16-bit LFSR stream.
//
//  state   | meaning
//  IDLE    | waiting for start; outputs quiet
//  DISCARD | sending discardCnt zero-valued dummy beats
//  STREAM  | sending frame pixels in raster order
//  DONE    | one cycle with done=1, then back to IDLE
module frame_stream_source
  import frame_stream_source_pkg::*;
#(
  parameter int DATA_WIDTH        = 8,
  parameter int CHANNELS          = 1,
  parameter int X_RES_WIDTH       = 11,
  parameter int Y_RES_WIDTH       = 11,
  parameter int DISCARD_CNT_WIDTH = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [X_RES_WIDTH-1:0]         xRes,
  input  logic [Y_RES_WIDTH-1:0]         yRes,
  input  logic [DISCARD_CNT_WIDTH-1:0]   discardCnt,
  input  logic [1:0]                     patternSel,
  output logic [DATA_WIDTH*CHANNELS-1:0] dOut,
  output logic                           dOutValid,
  input  logic                           nextDout,
  output logic                           busy,
  output logic                           done
);

  state_t                       state;
  logic [X_RES_WIDTH-1:0]       x_q, x_res_q, x_step;
  logic [Y_RES_WIDTH-1:0]       y_q, y_res_q, y_step;
  logic [DISCARD_CNT_WIDTH-1:0] disc_q;
  logic [1:0]                   pat_q, gen_pat;
  logic [7:0]                   gen_x, gen_y, v;
  logic [DATA_WIDTH-1:0]        pix;
  logic [DATA_WIDTH*CHANNELS-1:0] pix_rep;
  logic                         xfer, row_end, frame_end;

  assign xfer      = dOutValid && nextDout;
  assign row_end   = (x_q == x_res_q);
  assign frame_end = row_end && (y_q == y_res_q);
  assign x_step    = row_end ? '0 : x_q + X_RES_WIDTH'(1);
  assign y_step    = row_end ? y_q + Y_RES_WIDTH'(1) : y_q;

  // The generator always computes the pixel to be presented after the next edge.
  assign gen_pat = (state == IDLE) ? patternSel : pat_q;
  assign gen_x   = (state == STREAM) ? x_step[7:0] : 8'h00;
  assign gen_y   = (state == STREAM) ? y_step[7:0] : 8'h00;

`ifdef FRAME_SOURCE_LFSR_EN
  logic [15:0] lfsr_q, gen_lfsr;
  assign gen_lfsr = (state == IDLE)   ? LFSR_SEED :
                    (state == STREAM) ? lfsr_step(lfsr_q) : lfsr_q;
`endif

  stream_pattern_gen u_pattern (
    .x           (gen_x),
    .y           (gen_y),
    .pattern_sel (gen_pat),
`ifdef FRAME_SOURCE_LFSR_EN
    .lfsr        (gen_lfsr[7:0]),
`endif
    .v           (v)
  );

  // 8-bit pattern value is MSB-aligned on wider channels.
  generate
    if (DATA_WIDTH > 8) begin : g_wide
      assign pix = {v, {(DATA_WIDTH-8){1'b0}}};
    end else begin : g_narrow
      assign pix = v[DATA_WIDTH-1:0];
    end
  endgenerate

  assign pix_rep = {CHANNELS{pix}};

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      x_q       <= '0;
      y_q       <= '0;
      x_res_q   <= '0;
      y_res_q   <= '0;
      disc_q    <= '0;
      pat_q     <= '0;
      dOut      <= '0;
      dOutValid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef FRAME_SOURCE_LFSR_EN
      lfsr_q    <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            x_res_q   <= xRes;
            y_res_q   <= yRes;
            pat_q     <= patternSel;
            disc_q    <= discardCnt;
            x_q       <= '0;
            y_q       <= '0;
            dOutValid <= 1'b1;
            busy      <= 1'b1;
`ifdef FRAME_SOURCE_LFSR_EN
            lfsr_q    <= LFSR_SEED;
`endif
            if (discardCnt != '0) begin
              state <= DISCARD;
              dOut  <= '0;
            end else begin
              state <= STREAM;
              dOut  <= pix_rep;
            end
          end
        end
        DISCARD: begin
          if (xfer) begin
            disc_q <= disc_q - DISCARD_CNT_WIDTH'(1);
            if (disc_q == DISCARD_CNT_WIDTH'(1)) begin
              state <= STREAM;
              dOut  <= pix_rep;
            end
          end
        end
        STREAM: begin
          if (xfer) begin
            if (frame_end) begin
              state     <= DONE;
              dOut      <= '0;
              dOutValid <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
            end else begin
              x_q  <= x_step;
              y_q  <= y_step;
              dOut <= pix_rep;
`ifdef FRAME_SOURCE_LFSR_EN
              lfsr_q <= gen_lfsr;
`endif
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
